// File: rtl/tart_bank_switch.sv
// tart_bank_switch: accumulation window timer that swaps correlator banks and tracks visibility prefetch.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   active_i, en_i         run enable, one accepted correlator sample per cycle
//   blocksize_i            window length minus one
//   ready_i, clr_i         prefetch complete (rising edge clears pending), overflow clear strobe
//   switching_o, bank_o    one-cycle swap pulse, bank currently accumulating
//   pending_o, overflow_o  prefetch in flight, sticky overrun flag
//   windows_o              completed window count, modulo 2^16
module tart_bank_switch #(
    parameter int BLOCK = 32,
    parameter int BANKS = 2,
    parameter int BBITS = 1,
    parameter int DELAY = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             active_i,
    input  logic             en_i,
    input  logic [BLOCK-1:0] blocksize_i,
    input  logic             ready_i,
    input  logic             clr_i,
    output logic             switching_o,
    output logic [BBITS-1:0] bank_o,
    output logic             pending_o,
    output logic             overflow_o,
    output logic [15:0]      windows_o
);
    if (BBITS < $clog2(BANKS) || DELAY < 0) begin : g_bad_params
        $error("tart_bank_switch: BBITS too narrow for BANKS, or negative DELAY");
    end
    logic [BLOCK-1:0] cnt, len, cur_len;
    logic active_q, ready_q, first, wend;
    // The first active cycle compares against the incoming length, since len is only being latched now.
    always_comb begin
        first   = active_i && !active_q;
        cur_len = first ? blocksize_i : len;
        wend    = active_i && en_i && cnt == cur_len;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt         <= '0;
            len         <= '0;
            active_q    <= 1'b0;
            ready_q     <= 1'b0;
            switching_o <= 1'b0;
            bank_o      <= '0;
            pending_o   <= 1'b0;
            overflow_o  <= 1'b0;
            windows_o   <= '0;
        end else begin
            active_q    <= active_i;
            ready_q     <= ready_i;
            switching_o <= wend;
            if (!active_i)
                cnt <= '0;
            else if (en_i)
                cnt <= wend ? '0 : cnt + 1'b1;
            if (first || wend)
                len <= blocksize_i;
            if (wend) begin
                bank_o    <= (bank_o == BBITS'(BANKS - 1)) ? '0 : bank_o + 1'b1;
                windows_o <= windows_o + 16'd1;
            end
            // A new window end takes priority over a coincident prefetch completion.
            pending_o  <= wend | (pending_o & ~(ready_i & ~ready_q));
            overflow_o <= (wend & pending_o) | (overflow_o & ~clr_i);
        end
    end
endmodule

// File: tb/tb_tart_bank_switch.sv
// tb_tart_bank_switch: directed bench for tart_bank_switch (two and three bank instances).
module tb_tart_bank_switch;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        active_i = 1'b0;
    logic        en_i = 1'b0;
    logic [31:0] blocksize_i = 32'd3;
    logic        ready_i = 1'b0;
    logic        clr_i = 1'b0;
    logic        switching_o, pending_o, overflow_o;
    logic [0:0]  bank_o;
    logic [15:0] windows_o;
    logic        sw3, pend3, ovf3;
    logic [1:0]  bank3;
    logic [15:0] win3;
    int          passed = 0;
    int          total = 0;
    int          n;

    tart_bank_switch dut (
        .clk_i(clk_i), .rst_i(rst_i), .active_i(active_i), .en_i(en_i),
        .blocksize_i(blocksize_i), .ready_i(ready_i), .clr_i(clr_i),
        .switching_o(switching_o), .bank_o(bank_o), .pending_o(pending_o),
        .overflow_o(overflow_o), .windows_o(windows_o)
    );

    tart_bank_switch #(.BANKS(3), .BBITS(2)) dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .active_i(active_i), .en_i(en_i),
        .blocksize_i(blocksize_i), .ready_i(ready_i), .clr_i(clr_i),
        .switching_o(sw3), .bank_o(bank3), .pending_o(pend3),
        .overflow_o(ovf3), .windows_o(win3)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Ticks until switching_o, pulsing ready_i once on the third edge; bounded at 20 edges.
    task automatic measure(output int cycles);
        cycles = 0;
        do begin
            ready_i = (cycles == 2);
            tick();
            cycles++;
        end while (!switching_o && cycles < 20);
        ready_i = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_switching", switching_o, 0);
        check("rst_bank", bank_o, 0);
        check("rst_pending", pending_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_windows", windows_o, 0);
        rst_i = 1'b0;

        // T1: continuous samples, ready pulse two cycles after each swap
        active_i = 1'b1;
        en_i = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            for (int k = 0; k < 4; k++) begin
                ready_i = (k == 2);
                tick();
                if (k < 3) check("t1_no_switch", switching_o, 0);
                if (k == 2) check("t1_pending_clr", pending_o, 0);
            end
            ready_i = 1'b0;
            check("t1_switch", switching_o, 1);
            check("t1_bank", bank_o, w % 2);
            check("t1_bank3", bank3, w % 3);
            check("t1_windows", windows_o, w);
            check("t1_pending", pending_o, 1);
            check("t1_overflow", overflow_o, 0);
        end
        en_i = 1'b0;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        tick();
        check("t1_drained", pending_o, 0);

        // T2: one sample every third cycle
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 4; s++) begin
                en_i = 1'b1;
                ready_i = 1'b0;
                tick();
                en_i = 1'b0;
                check("t2_switch", switching_o, s == 3);
                tick();
                check("t2_single_pulse", switching_o, 0);
                ready_i = 1'b1;
                tick();
            end
        end
        ready_i = 1'b0;
        check("t2_windows", windows_o, 6);
        check("t2_bank", bank_o, 0);
        check("t2_overflow", overflow_o, 0);

        // T3: blocksize change mid-window applies to the following window
        en_i = 1'b1;
        tick();
        blocksize_i = 32'd7;
        tick();
        tick();
        check("t3_no_switch_early", switching_o, 0);
        tick();
        check("t3_old_len", switching_o, 1);
        measure(n);
        check("t3_new_len", n, 8);
        check("t3_overflow", overflow_o, 0);
        check("t3_windows", windows_o, 8);

        // T4: blocksize 0, ready held low; back-to-back swaps and overruns
        active_i = 1'b0;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        tick();
        check("t4_idle_pending", pending_o, 0);
        check("t4_idle_switch", switching_o, 0);
        blocksize_i = 32'd0;
        active_i = 1'b1;
        tick();
        check("t4_sw1", switching_o, 1);
        check("t4_ovf1", overflow_o, 0);
        tick();
        check("t4_sw2", switching_o, 1);
        check("t4_ovf2", overflow_o, 1);
        tick();
        clr_i = 1'b1;
        tick();
        check("t4_clr_vs_overrun", overflow_o, 1);
        en_i = 1'b0;
        tick();
        clr_i = 1'b0;
        check("t4_clr", overflow_o, 0);
        check("t4_windows", windows_o, 12);
        check("t4_bank3", bank3, 0);

        // T5: reset after two of four samples
        active_i = 1'b0;
        blocksize_i = 32'd3;
        tick();
        active_i = 1'b1;
        en_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        check("t5_rst_bank", bank_o, 0);
        check("t5_rst_windows", windows_o, 0);
        check("t5_rst_pending", pending_o, 1'b0);
        rst_i = 1'b0;
        tick();
        check("t5_no_switch_after_rst", switching_o, 0);
        measure(n);
        check("t5_full_window", n, 3);
        check("t5_windows", windows_o, 1);

        // T6: three banks wrap; idle gap discards a partial window
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        measure(n);
        check("t6_len_a", n, 4);
        check("t6_bank_a", bank3, 1);
        measure(n);
        check("t6_bank_b", bank3, 2);
        measure(n);
        check("t6_bank_c", bank3, 0);
        check("t6_overflow", ovf3, 0);
        tick();
        tick();
        active_i = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n += int'(sw3);
        end
        check("t6_idle_no_switch", n, 0);
        check("t6_idle_bank", bank3, 0);
        active_i = 1'b1;
        measure(n);
        check("t6_discarded", n, 4);
        check("t6_bank_d", bank3, 1);
        check("t6_windows", win3, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
